shared_unit_arbiter: RTL and testbench

//   Round-robin arbiter sharing one logic unit (e.g. the NOR_GATE/ALU operand path) between
//   NUM_REQ requesters. Level-sensitive request/grant handshake; the owner holds the unit

---
 rtl/shared_unit_arbiter.sv | 124 ++++++++++++
 tb/tb_shared_unit_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/shared_unit_arbiter.sv
// rtl/shared_unit_arbiter.sv - round-robin arbiter for one shared logic unit (optional SHARED_ARB_TIMEOUT_EN)
module shared_unit_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int HOLD_MAX = 15
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [NUM_REQ-1:0]  Request,
    output logic [NUM_REQ-1:0]  Grant,
    output logic [ID_WIDTH-1:0] Grant_Id,
    output logic                Busy,
    output logic                Timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               state_q;
    logic [ID_WIDTH-1:0]  ptr_q;
    logic [ID_WIDTH-1:0]  ptr_d;
    logic [NUM_REQ-1:0]   eligible;
    logic                 sel_found;
    logic [ID_WIDTH-1:0]  sel_idx;
    logic [NUM_REQ-1:0]   sel_onehot;

`ifdef SHARED_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0]     hold_q;
    logic [NUM_REQ-1:0]   mask_q;
    logic                 hold_expired;

    // Requesters revoked by the watchdog stay ineligible until they drop their request
    assign eligible     = Request & ~mask_q;
    assign hold_expired = (hold_q == CNT_W'(HOLD_MAX - 1));
`else
    assign eligible = Request;
`endif

    // Pointer for the next arbitration once the current owner leaves
    assign ptr_d = (Grant_Id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : Grant_Id + 1'b1;

    // First eligible requester at or after the pointer, wrapping to index 0
    always_comb begin
        int unsigned p;
        sel_found = 1'b0;
        sel_idx   = '0;
        p         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            p = int'(ptr_q) + k;
            if (p >= NUM_REQ) begin
                p = p - NUM_REQ;
            end
            if (!sel_found && eligible[ID_WIDTH'(p)]) begin
                sel_found = 1'b1;
                sel_idx   = ID_WIDTH'(p);
            end
        end
        sel_onehot = NUM_REQ'(1) << sel_idx;
    end

    // Arbitration FSM; grant outputs are registered, handover always passes through IDLE
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            Grant    <= '0;
            Grant_Id <= '0;
            Busy     <= 1'b0;
            Timeout  <= 1'b0;
            ptr_q    <= '0;
`ifdef SHARED_ARB_TIMEOUT_EN
            hold_q   <= '0;
            mask_q   <= '0;
`endif
        end else begin
            Timeout <= 1'b0;
`ifdef SHARED_ARB_TIMEOUT_EN
            // A revoked requester is forgiven on the first edge it is seen low
            mask_q  <= mask_q & Request;
`endif
            case (state_q)
                S_IDLE: begin
                    if (sel_found) begin
                        state_q  <= S_GRANT;
                        Grant    <= sel_onehot;
                        Grant_Id <= sel_idx;
                        Busy     <= 1'b1;
`ifdef SHARED_ARB_TIMEOUT_EN
                        hold_q   <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (!Request[Grant_Id]) begin
                        state_q  <= S_IDLE;
                        Grant    <= '0;
                        Grant_Id <= '0;
                        Busy     <= 1'b0;
                        ptr_q    <= ptr_d;
`ifdef SHARED_ARB_TIMEOUT_EN
                    end else if (hold_expired) begin
                        state_q          <= S_IDLE;
                        Grant            <= '0;
                        Grant_Id         <= '0;
                        Busy             <= 1'b0;
                        ptr_q            <= ptr_d;
                        Timeout          <= 1'b1;
                        mask_q[Grant_Id] <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// tb/tb_shared_unit_arbiter.sv - scoreboard bench for shared_unit_arbiter
module tb_shared_unit_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic [3:0] Request;
    logic [3:0] Grant;
    logic [1:0] Grant_Id;
    logic       Busy;
    logic       Timeout;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    shared_unit_arbiter #(
        .NUM_REQ (4),
        .ID_WIDTH(2),
        .HOLD_MAX(15)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Request (Request),
        .Grant   (Grant),
        .Grant_Id(Grant_Id),
        .Busy    (Busy),
        .Timeout (Timeout)
    );

    always #5 Clock = ~Clock;

    // One clock of stimulus; the expected registered response after that edge goes to the scoreboard
    task automatic cyc(input logic rn, input logic [3:0] req, input logic [3:0] g,
                       input logic [1:0] id, input logic to, input string nm);
        Reset_n = rn;
        Request = req;
        @(posedge Clock);
        exp_q.push_back({g, id, |g, to});
        name_q.push_back(nm);
        @(negedge Clock);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation, plus structural invariants
    always @(negedge Clock) begin
        exp_t  e;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if ({Grant, Grant_Id, Busy, Timeout} !== e) begin
                n_fail++;
                $display("FAIL %s: got grant=%b id=%0d busy=%b to=%b, want grant=%b id=%0d busy=%b to=%b",
                         nm, Grant, Grant_Id, Busy, Timeout, e.g, e.id, e.busy, e.to);
            end
            n_checks++;
            if (($countones(Grant) > 1) || (Busy !== (|Grant))) begin
                n_fail++;
                $display("FAIL invariant_%s: got grant=%b busy=%b, want onehot0 grant with busy=|grant",
                         nm, Grant, Busy);
            end
        end
    end

    initial begin
        Reset_n = 1'b0;
        Request = 4'b0000;
        @(negedge Clock);

        // Reset with all requests raised
        cyc(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset0");
        cyc(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset1");

        // Round-robin from pointer 0, each owner holds three cycles then releases
        for (int k = 0; k < 4; k++) begin
            logic [3:0] own;
            own = 4'b0001 << k;
            cyc(1'b1, 4'b1111, own, 2'(k), 1'b0, "rr_grant");
            cyc(1'b1, 4'b1111, own, 2'(k), 1'b0, "rr_hold1");
            cyc(1'b1, 4'b1111, own, 2'(k), 1'b0, "rr_hold2");
            cyc(1'b1, 4'b1111 & ~own, 4'b0000, 2'd0, 1'b0, "rr_gap");
        end
        cyc(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, "rr_wrap0");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_release0");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_a");

        // Single requester 2 (pointer is 1 here)
        cyc(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_grant");
        cyc(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_hold");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "single_release");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "single_idle");

        // Pointer 3 with requesters 0 and 3: 3 first, then wrap to 0
        cyc(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b0, "wrap_grant3");
        cyc(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b0, "wrap_hold3");
        cyc(1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, "wrap_gap");
        cyc(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, "wrap_grant0");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "wrap_release0");

        // Reset in the middle of a grant to requester 1 (pointer is 1 beforehand)
        cyc(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, "mid_grant1");
        cyc(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, "mid_hold1");
        cyc(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, "mid_reset");
        cyc(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, "post_reset_ptr0");
        cyc(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, "post_reset_release");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "post_reset_idle");

`ifdef SHARED_ARB_TIMEOUT_EN
        // Watchdog: owner 0 revoked after 15 grant cycles, then masked until it drops
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_reset");
        cyc(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, "to_grant0");
        for (int k = 0; k < 14; k++) begin
            cyc(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, "to_hold0");
        end
        cyc(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b1, "to_pulse");
        cyc(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b0, "to_grant1");
        cyc(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b0, "to_hold1");
        cyc(1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, "to_release1");
        cyc(1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, "to_masked0");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_unmask");
        cyc(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, "to_regrant0");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_release0");
`endif

        repeat (2) @(negedge Clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
